masked_cf_pipe: RTL and testbench

//  Parametrised, pipelined masked component-function layer for the SKINNY masked S-box.
//  Per lane, computes two shared functions: f1 = a ^ (b & d) and f2 = b ^ (c & d).

---
 rtl/masked_cf_pipe_if.sv | 30 +++
 rtl/masked_cf_pipe.sv | 113 +++++++++++
 tb/tb_masked_cf_pipe.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/masked_cf_pipe_if.sv
// Handshake and share bus of the masked component-function pipe.
// The master drives the inputs and out_ready; the slave is the pipe.
interface masked_cf_pipe_if #(
  parameter int SHARES = 3,
  parameter int WIDTH  = 1
);
  localparam int NCROSS = SHARES * (SHARES - 1);

  logic                        in_valid;
  logic                        in_ready;
  logic [SHARES*WIDTH-1:0]     a;
  logic [SHARES*WIDTH-1:0]     b;
  logic [SHARES*WIDTH-1:0]     c;
  logic [SHARES*WIDTH-1:0]     d;
  logic [2*WIDTH*NCROSS-1:0]   rnd;
  logic                        out_valid;
  logic                        out_ready;
  logic [SHARES*WIDTH-1:0]     q1;
  logic [SHARES*WIDTH-1:0]     q2;

  modport master (
    output in_valid, a, b, c, d, rnd, out_ready,
    input  in_ready, out_valid, q1, q2
  );

  modport slave (
    input  in_valid, a, b, c, d, rnd, out_ready,
    output in_ready, out_valid, q1, q2
  );
endinterface

// File: rtl/masked_cf_pipe.sv
// Two-stage masked layer computing f1 = a ^ (b & d) and f2 = b ^ (c & d) on Boolean shares.
// Stage 1 registers every product term (glitch barrier); stage 2 compresses terms per output share.
module masked_cf_pipe #(
  parameter int SHARES = 3,
  parameter int WIDTH  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  masked_cf_pipe_if.slave bus
);
  localparam int NCROSS = SHARES * (SHARES - 1);
  localparam int RHALF  = WIDTH * NCROSS;

  typedef logic [WIDTH-1:0][SHARES-1:0][SHARES-1:0] term_t;

  term_t                   t1_q, t1_d;
  term_t                   t2_q, t2_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    out_valid_q, out_valid_d;
  logic [SHARES*WIDTH-1:0] q1_q, q1_d;
  logic [SHARES*WIDTH-1:0] q2_q, q2_d;

  logic s2_ready;
  logic in_ready;
  logic in_fire;
  logic s1_adv;

  // Ring position of cross pair (i,j): i-major, j ascending, diagonal skipped.
  function automatic int kidx(input int i, input int j);
    return i * (SHARES - 1) + ((j < i) ? j : j - 1);
  endfunction

  assign s2_ready  = !out_valid_q || bus.out_ready;
  assign in_ready  = !s1_valid_q || s2_ready;
  assign in_fire   = bus.in_valid && in_ready;
  assign s1_adv    = s1_valid_q && s2_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.q1        = q1_q;
  assign bus.q2        = q2_q;

  always_comb begin
    t1_d = t1_q;
    t2_d = t2_q;
    if (in_fire) begin
      for (int l = 0; l < WIDTH; l++) begin
        for (int i = 0; i < SHARES; i++) begin
          for (int j = 0; j < SHARES; j++) begin
            if (i == j) begin
              t1_d[l][i][j] = bus.a[i*WIDTH+l] ^ (bus.b[i*WIDTH+l] & bus.d[i*WIDTH+l]);
              t2_d[l][i][j] = bus.b[i*WIDTH+l] ^ (bus.c[i*WIDTH+l] & bus.d[i*WIDTH+l]);
            end else begin
              // Each ring bit is used by two neighbouring terms, so the refresh cancels overall.
              t1_d[l][i][j] = (bus.b[i*WIDTH+l] & bus.d[j*WIDTH+l])
                            ^ bus.rnd[l*NCROSS + kidx(i, j)]
                            ^ bus.rnd[l*NCROSS + (kidx(i, j) + 1) % NCROSS];
              t2_d[l][i][j] = (bus.c[i*WIDTH+l] & bus.d[j*WIDTH+l])
                            ^ bus.rnd[RHALF + l*NCROSS + kidx(i, j)]
                            ^ bus.rnd[RHALF + l*NCROSS + (kidx(i, j) + 1) % NCROSS];
            end
          end
        end
      end
    end
  end

  always_comb begin
    q1_d = q1_q;
    q2_d = q2_q;
    if (s1_adv) begin
      for (int l = 0; l < WIDTH; l++) begin
        for (int i = 0; i < SHARES; i++) begin
          q1_d[i*WIDTH+l] = ^t1_q[l][i];
          q2_d[i*WIDTH+l] = ^t2_q[l][i];
        end
      end
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (s1_adv) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      t1_q        <= '0;
      t2_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      q1_q        <= '0;
      q2_q        <= '0;
    end else begin
      t1_q        <= t1_d;
      t2_q        <= t2_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      q1_q        <= q1_d;
      q2_q        <= q2_d;
    end
  end
endmodule

// File: tb/tb_masked_cf_pipe.sv
// Bench for masked_cf_pipe: SHARES=3/WIDTH=1 and SHARES=4/WIDTH=4 instances checked against an
// unmasked scoreboard, plus hand-computed share vectors and handshake corner sequences.
module tb_masked_cf_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  masked_cf_pipe_if #(.SHARES(3), .WIDTH(1)) ifc3 ();
  masked_cf_pipe_if #(.SHARES(4), .WIDTH(4)) ifc4 ();

  masked_cf_pipe #(.SHARES(3), .WIDTH(1)) dut3 (.clk(clk), .rst_n(rst_n), .bus(ifc3));
  masked_cf_pipe #(.SHARES(4), .WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(ifc4));

  int errors = 0;
  int checks = 0;
  int out3_cnt = 0;
  int out4_cnt = 0;
  logic [7:0] sb3[$];
  logic [7:0] sb4[$];

  typedef struct {
    logic [2:0]  a, b, c, d;
    logic [11:0] rnd;
    logic [2:0]  e1, e2;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Unmasked value of lane l: XOR of all its shares.
  function automatic logic ux(input logic [15:0] v, input int s, input int w, input int l);
    logic r = 1'b0;
    for (int i = 0; i < s; i++) r ^= v[i*w+l];
    return r;
  endfunction

  function automatic logic [3:0] unm(input logic [15:0] v, input int s, input int w);
    logic [3:0] r = '0;
    for (int l = 0; l < w; l++) r[l] = ux(v, s, w, l);
    return r;
  endfunction

  function automatic logic [3:0] model(input logic [15:0] x, y, z, input int s, input int w);
    logic [3:0] r = '0;
    for (int l = 0; l < w; l++) r[l] = ux(x, s, w, l) ^ (ux(y, s, w, l) & ux(z, s, w, l));
    return r;
  endfunction

  // SHARES=3: ring bit m feeds cross terms m and m-1; term k belongs to output share k/2.
  function automatic logic [2:0] flip_mask3(input int m);
    logic [2:0] r = '0;
    r[m/2] = ~r[m/2];
    r[((m + 5) % 6)/2] = ~r[((m + 5) % 6)/2];
    return r;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      sb3.delete();
      sb4.delete();
    end else begin
      if (ifc3.out_valid && ifc3.out_ready) begin
        out3_cnt++;
        if (sb3.size() == 0) chk("sb3_underflow", 64'(sb3.size()), 64'd1);
        else chk("sb3_unmasked", {56'd0, unm(16'(ifc3.q2), 3, 1), unm(16'(ifc3.q1), 3, 1)},
                 64'(sb3.pop_front()));
      end
      if (ifc3.in_valid && ifc3.in_ready)
        sb3.push_back({model(16'(ifc3.b), 16'(ifc3.c), 16'(ifc3.d), 3, 1),
                       model(16'(ifc3.a), 16'(ifc3.b), 16'(ifc3.d), 3, 1)});
      if (ifc4.out_valid && ifc4.out_ready) begin
        out4_cnt++;
        if (sb4.size() == 0) chk("sb4_underflow", 64'(sb4.size()), 64'd1);
        else chk("sb4_unmasked", {56'd0, unm(ifc4.q2, 4, 4), unm(ifc4.q1, 4, 4)},
                 64'(sb4.pop_front()));
      end
      if (ifc4.in_valid && ifc4.in_ready)
        sb4.push_back({model(ifc4.b, ifc4.c, ifc4.d, 4, 4), model(ifc4.a, ifc4.b, ifc4.d, 4, 4)});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beat3(input logic [2:0] a, b, c, d, input logic [11:0] r,
                           output logic [2:0] q1, q2, output int lat);
    int waitc = 0;
    ifc3.a = a; ifc3.b = b; ifc3.c = c; ifc3.d = d; ifc3.rnd = r;
    ifc3.out_ready = 1'b1;
    ifc3.in_valid = 1'b1;
    while (!ifc3.in_ready && waitc < 10) begin tick(); waitc++; end
    tick();
    ifc3.in_valid = 1'b0;
    lat = 1;
    while (!ifc3.out_valid && lat < 10) begin tick(); lat++; end
    q1 = ifc3.q1;
    q2 = ifc3.q2;
    tick();
  endtask

  task automatic run_beat4(input logic [15:0] a, b, c, d, input logic [95:0] r,
                           output logic [15:0] q1, q2);
    int lat = 0;
    ifc4.a = a; ifc4.b = b; ifc4.c = c; ifc4.d = d; ifc4.rnd = r;
    ifc4.out_ready = 1'b1;
    ifc4.in_valid = 1'b1;
    tick();
    ifc4.in_valid = 1'b0;
    while (!ifc4.out_valid && lat < 10) begin tick(); lat++; end
    chk("dut4_beat_done", 64'(ifc4.out_valid), 64'd1);
    q1 = ifc4.q1;
    q2 = ifc4.q2;
    tick();
  endtask

  task automatic rand3();
    ifc3.a = 3'($urandom); ifc3.b = 3'($urandom); ifc3.c = 3'($urandom);
    ifc3.d = 3'($urandom); ifc3.rnd = 12'($urandom);
  endtask

  // Offer beats for 5 cycles with out_ready low; returns how many were accepted.
  task automatic fill_stall3(output int acc, output logic [2:0] h1, h2);
    logic fired;
    acc = 0;
    h1 = '0;
    h2 = '0;
    ifc3.out_ready = 1'b0;
    ifc3.in_valid = 1'b1;
    rand3();
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      fired = ifc3.in_valid && ifc3.in_ready;
      if (fired) acc++;
      if (cyc == 2) begin h1 = ifc3.q1; h2 = ifc3.q2; end
      tick();
      if (fired) rand3();
    end
    ifc3.in_valid = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    logic [2:0]  g1, g2, h1, h2;
    logic [15:0] qa1, qa2, qb1, qb2, a4, b4, c4, d4, lmask;
    logic [95:0] r4;
    int lat, acc, base, stalls;

    vecs[0] = '{3'b001, 3'b011, 3'b000, 3'b100, 12'h000, 3'b010, 3'b011};
    vecs[1] = '{3'b001, 3'b011, 3'b000, 3'b100, 12'h001, 3'b111, 3'b011};
    vecs[2] = '{3'b001, 3'b011, 3'b000, 3'b100, 12'h004, 3'b001, 3'b011};
    vecs[3] = '{3'b001, 3'b011, 3'b000, 3'b100, 12'h040, 3'b010, 3'b110};
    vecs[4] = '{3'b000, 3'b000, 3'b000, 3'b000, 12'h000, 3'b000, 3'b000};
    vecs[5] = '{3'b000, 3'b000, 3'b111, 3'b111, 12'h000, 3'b000, 3'b111};

    ifc3.in_valid = 1'b0; ifc3.out_ready = 1'b1; ifc3.a = '0; ifc3.b = '0;
    ifc3.c = '0; ifc3.d = '0; ifc3.rnd = '0;
    ifc4.in_valid = 1'b0; ifc4.out_ready = 1'b1; ifc4.a = '0; ifc4.b = '0;
    ifc4.c = '0; ifc4.d = '0; ifc4.rnd = '0;

    repeat (3) tick();
    chk("rst_out_valid3", 64'(ifc3.out_valid), 64'd0);
    chk("rst_in_ready3", 64'(ifc3.in_ready), 64'd1);
    chk("rst_q1_3", 64'(ifc3.q1), 64'd0);
    chk("rst_out_valid4", 64'(ifc4.out_valid), 64'd0);
    rst_n = 1'b1;
    tick();

    foreach (vecs[v]) begin
      run_beat3(vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].d, vecs[v].rnd, g1, g2, lat);
      chk($sformatf("vec%0d_latency", v), 64'(lat), 64'd2);
      chk($sformatf("vec%0d_q1", v), 64'(g1), 64'(vecs[v].e1));
      chk($sformatf("vec%0d_q2", v), 64'(g2), 64'(vecs[v].e2));
    end

    // Single ring-bit sweep on the hand vector: share flips follow ring indices k and k+1.
    for (int m = 0; m < 12; m++) begin
      run_beat3(3'b001, 3'b011, 3'b000, 3'b100, 12'(1) << m, g1, g2, lat);
      chk($sformatf("ring%0d_q1", m), 64'(g1), 64'(3'b010 ^ ((m < 6) ? flip_mask3(m) : 3'b000)));
      chk($sformatf("ring%0d_q2", m), 64'(g2), 64'(3'b011 ^ ((m >= 6) ? flip_mask3(m - 6) : 3'b000)));
    end

    base = out3_cnt;
    fill_stall3(acc, h1, h2);
    chk("stall_accepted", 64'(acc), 64'd2);
    chk("stall_in_ready", 64'(ifc3.in_ready), 64'd0);
    chk("stall_q1_held", 64'(ifc3.q1), 64'(h1));
    chk("stall_q2_held", 64'(ifc3.q2), 64'(h2));
    ifc3.out_ready = 1'b1;
    repeat (4) tick();
    chk("stall_drain_count", 64'(out3_cnt - base), 64'd2);
    chk("stall_drain_empty", 64'(sb3.size()), 64'd0);

    fill_stall3(acc, h1, h2);
    chk("rst_fill_accepted", 64'(acc), 64'd2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(ifc3.out_valid), 64'd0);
    chk("async_rst_in_ready", 64'(ifc3.in_ready), 64'd1);
    chk("async_rst_q", {ifc3.q1, ifc3.q2}, 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_beat3(3'b001, 3'b011, 3'b000, 3'b100, 12'h000, g1, g2, lat);
    chk("post_rst_latency", 64'(lat), 64'd2);
    chk("post_rst_q1", 64'(g1), 64'(3'b010));
    chk("post_rst_q2", 64'(g2), 64'(3'b011));

    base = out3_cnt;
    stalls = 0;
    ifc3.out_ready = 1'b1;
    for (int p = 0; p < 4096; p++) begin
      {ifc3.a, ifc3.b, ifc3.c, ifc3.d} = 12'(p);
      ifc3.rnd = 12'($urandom);
      ifc3.in_valid = 1'b1;
      @(negedge clk);
      if (!ifc3.in_ready) stalls++;
      tick();
    end
    ifc3.in_valid = 1'b0;
    repeat (4) tick();
    chk("exh_stalls", 64'(stalls), 64'd0);
    chk("exh_outputs", 64'(out3_cnt - base), 64'd4096);
    chk("exh_empty", 64'(sb3.size()), 64'd0);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      ifc4.in_valid = 1'($urandom);
      ifc4.a = 16'($urandom); ifc4.b = 16'($urandom);
      ifc4.c = 16'($urandom); ifc4.d = 16'($urandom);
      ifc4.rnd = {$urandom, $urandom, $urandom};
      ifc4.out_ready = ($urandom_range(3) != 0);
      tick();
    end
    ifc4.in_valid = 1'b0;
    ifc4.out_ready = 1'b1;
    repeat (4) tick();
    chk("rand4_empty", 64'(sb4.size()), 64'd0);
    chk("rand4_active", 64'(out4_cnt > 100), 64'd1);

    a4 = 16'($urandom); b4 = 16'($urandom); c4 = 16'($urandom); d4 = 16'($urandom);
    r4 = {$urandom, $urandom, $urandom};
    run_beat4(a4, b4, c4, d4, r4, qa1, qa2);
    for (int l = 0; l < 4; l++) begin
      int s = $urandom_range(3);
      lmask = 16'h1111 << l;
      run_beat4(a4 ^ (16'(1) << (s*4 + l)), b4, c4, d4, r4, qb1, qb2);
      chk($sformatf("lane%0d_q1_isolated", l), 64'((qa1 ^ qb1) & ~lmask), 64'd0);
      chk($sformatf("lane%0d_q2_isolated", l), 64'((qa2 ^ qb2) & ~lmask), 64'd0);
      chk($sformatf("lane%0d_f1_flip", l), 64'(ux(qa1, 4, 4, l) ^ ux(qb1, 4, 4, l)), 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
